sha256_msg_pad: RTL
===================

Name: sha256_msg_pad

Overview:
- Producer-side front end for the SHA-256 compression datapath.
- Accepts an arbitrary-length byte message as big-endian 32-bit words over a valid/ready stream.
- Applies FIPS 180-4 padding: a 0x80 marker byte, zero fill, and a 64-bit big-endian bit length.
- Emits 16-word blocks, with block and message framing flags, to the round/schedule logic that consumes W[0..15].

Parameters:
- LEN_W, 64, width of the message bit-length counter. The counter wraps modulo 2^LEN_W. Only 64 is supported in the length words; a smaller value zero-extends into word 14/15.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted when in_valid&&in_ready
- in_data  in  32  message word; message byte k of the word is in_data[31-8k -: 8]
- in_last  in  1  final word of the message
- in_nbytes  in  3  number of valid bytes on the in_last word, 0..4; ignored when in_last=0; values 5..7 are treated as 4
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts when out_valid&&out_ready
- out_data  out  32  padded block word
- out_first  out  1  out_data is word 0 of a block
- out_blk_last  out  1  out_data is word 15 of a block
- out_msg_last  out  1  out_data is word 15 of the final block of the message
- busy  out  1  a message is in progress (first word accepted, final length word not yet transferred)

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_data=0, all flags=0, busy=0, in_ready=0.
  - State S_DATA, word index widx=0, bit counter=0.
  - Reset mid-message discards the partial message; no partial block is emitted after release.
- Output register: a single registered stage.
  - It loads when (!out_valid || out_ready).
  - Latency from an accepted input word to its out_valid is 1 cycle.
  - Full throughput of 1 word/cycle in S_DATA.
  - out_data and the flags are held stable while out_valid && !out_ready.
- in_ready = (state==S_DATA) && (!out_valid || out_ready). No input is accepted in any padding state.
- widx (4 bits) counts transferred output words within a block and wraps 15->0.
  - out_first = (widx==0).
  - out_blk_last = (widx==15).
- Bit counter:
  - +32 per accepted non-last word.
  - +8*in_nbytes on the last word.
  - Modulo 2^LEN_W.
- States:
  - S_DATA, non-last word: emit in_data unchanged.
  - S_DATA, last word with n=in_nbytes<4: emit data bytes 0..n-1, byte n=0x80, remaining bytes 0. n=0 emits 0x80000000 and in_data is ignored. Next state is S_ZERO, or S_LEN_HI if this word sits at widx 13.
  - S_DATA, last word with n=4: emit in_data unchanged. Next state S_MARK.
  - S_MARK: emit 0x80000000, then go to S_ZERO or S_LEN_HI by the same rule.
  - S_ZERO: emit 0x00000000 until the word at widx 13 has been emitted, then go to S_LEN_HI.
    - If the marker lands at widx 14 or 15, zeros continue through widx 15 and words 0..13 of the next block.
    - That extra block's word 0 asserts out_first.
  - S_LEN_HI (widx 14): emit counter[63:32].
  - S_LEN_LO (widx 15): emit counter[31:0] with out_msg_last=1. After transfer: counter=0, busy=0, state S_DATA, widx=0.
- A new message's first word may be accepted in the same cycle that the S_LEN_LO word transfers (back-to-back messages, no bubble).
- Total blocks emitted per message = floor((bytes+8)/64)+1.

Decomposition:
- Package sha256_pkg holds:
  - the 32-bit word type
  - BLK_WORDS=16
  - LEN_HI_IDX=14, LEN_LO_IDX=15
  - PAD_MARK=32'h80000000
  - the state enum {S_DATA,S_MARK,S_ZERO,S_LEN_HI,S_LEN_LO}
- One sub-module: sha256_pad_mask. It is combinational and maps (in_data, in_nbytes) to the marked last word.
- The FSM, counters and output register stay in sha256_msg_pad.

Test Plan:
- Empty message (in_last=1, in_nbytes=0) -> 1 block: word0=0x80000000 with out_first, words1-15=0, word15 with out_msg_last; length=0.
- "abc" (in_data=0x61626300, last, nbytes=3) -> word0=0x61626380, words1-14=0, word15=0x00000018 with out_blk_last and out_msg_last.
- 55 bytes (13 full words + last nbytes=3) -> single block: word13 ends 0x80, word14=0, word15=0x000001B8.
- 56 bytes (14 full words, last nbytes=4 at widx13):
  - Block 1: word14=0x80000000, word15=0 with out_blk_last and no out_msg_last.
  - Block 2: words0-13=0, word14=0, word15=0x000001C0 with out_msg_last.
- Backpressure: out_ready toggled randomly during a 3-word message -> out_data stable while stalled, no word lost or duplicated, in_ready low whenever the output is stalled.
- rst_n pulsed low at widx 7 of a message -> out_valid drops immediately. A following "abc" message produces exactly the "abc" block.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padding front end.
package sha256_pkg;

   typedef logic [31:0] word_t;

   localparam int unsigned BLK_WORDS = 16;
   localparam int unsigned WIDX_W    = $clog2(BLK_WORDS);

   typedef logic [WIDX_W-1:0] widx_t;

   localparam widx_t LEN_HI_IDX = widx_t'(14);
   localparam widx_t LEN_LO_IDX = widx_t'(15);
   localparam word_t PAD_MARK   = 32'h8000_0000;

   typedef enum logic [2:0] {
      S_DATA,
      S_MARK,
      S_ZERO,
      S_LEN_HI,
      S_LEN_LO
   } state_e;

   // Byte counts above a full word collapse to a full word.
   function automatic logic [2:0] clamp_nbytes(input logic [2:0] n);
      return (n > 3'd4) ? 3'd4 : n;
   endfunction

endpackage

// File: rtl/sha256_pad_mask.sv
// Builds the final message word: keeps the valid bytes, places the 0x80 marker
// right after them and zeroes the rest.
module sha256_pad_mask
   import sha256_pkg::*;
(
   input  word_t      data_i,
   input  logic [2:0] nbytes_i,
   output word_t      data_o
);

   logic [2:0] n;

   assign n = clamp_nbytes(nbytes_i);

   always_comb begin
      data_o = '0;
      for (int k = 0; k < 4; k++) begin
         if (3'(k) < n) begin
            data_o[31-8*k -: 8] = data_i[31-8*k -: 8];
         end else if (3'(k) == n) begin
            data_o[31-8*k -: 8] = 8'h80;
         end
      end
   end

endmodule

// File: rtl/sha256_msg_pad.sv
// SHA-256 message padder: streams message words in and emits padded 16-word
// blocks through a single registered output stage.
module sha256_msg_pad
   import sha256_pkg::*;
#(
   parameter int unsigned LEN_W = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic        in_last,
   input  logic [2:0]  in_nbytes,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_first,
   output logic        out_blk_last,
   output logic        out_msg_last,
   output logic        busy
);

   state_e           state_q, state_d;
   widx_t            widx_q, widx_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic             out_valid_q, out_valid_d;
   word_t            out_data_q, out_data_d;
   logic             out_first_q, out_first_d;
   logic             out_blk_last_q, out_blk_last_d;
   logic             out_msg_last_q, out_msg_last_d;
   logic             busy_q, busy_d;
   logic             en_q;

   logic       load;
   logic       accept;
   logic       gen;
   logic       zero_end;
   logic [2:0] nb;
   word_t      mask_word;
   word_t      word_sel;
   logic [63:0] len64;
   state_e     tail_state;

   sha256_pad_mask u_pad_mask (
      .data_i   (in_data),
      .nbytes_i (in_nbytes),
      .data_o   (mask_word)
   );

   // en_q keeps in_ready low while reset is asserted and for the first edge after it.
   assign load       = !out_valid_q || out_ready;
   assign in_ready   = en_q && (state_q == S_DATA) && load;
   assign accept     = in_valid && in_ready;
   assign gen        = (state_q == S_DATA) ? accept : load;
   assign nb         = clamp_nbytes(in_nbytes);
   assign zero_end   = (widx_q == LEN_HI_IDX - widx_t'(1));
   assign tail_state = zero_end ? S_LEN_HI : S_ZERO;
   assign len64      = 64'(cnt_q);

   assign out_valid    = out_valid_q;
   assign out_data     = out_data_q;
   assign out_first    = out_first_q;
   assign out_blk_last = out_blk_last_q;
   assign out_msg_last = out_msg_last_q;
   assign busy         = busy_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_DATA;
         widx_q         <= '0;
         cnt_q          <= '0;
         out_valid_q    <= 1'b0;
         out_data_q     <= '0;
         out_first_q    <= 1'b0;
         out_blk_last_q <= 1'b0;
         out_msg_last_q <= 1'b0;
         busy_q         <= 1'b0;
         en_q           <= 1'b0;
      end else begin
         state_q        <= state_d;
         widx_q         <= widx_d;
         cnt_q          <= cnt_d;
         out_valid_q    <= out_valid_d;
         out_data_q     <= out_data_d;
         out_first_q    <= out_first_d;
         out_blk_last_q <= out_blk_last_d;
         out_msg_last_q <= out_msg_last_d;
         busy_q         <= busy_d;
         en_q           <= 1'b1;
      end
   end

   always_comb begin : p_next_state
      state_d = state_q;
      unique case (state_q)
         S_DATA: begin
            if (accept && in_last) begin
               state_d = (nb == 3'd4) ? S_MARK : tail_state;
            end
         end
         S_MARK:   if (gen) state_d = tail_state;
         S_ZERO:   if (gen && zero_end) state_d = S_LEN_HI;
         S_LEN_HI: if (gen) state_d = S_LEN_LO;
         S_LEN_LO: if (gen) state_d = S_DATA;
         default:  state_d = S_DATA;
      endcase
   end

   always_comb begin : p_datapath
      unique case (state_q)
         S_DATA:   word_sel = in_last ? mask_word : in_data;
         S_MARK:   word_sel = PAD_MARK;
         S_ZERO:   word_sel = '0;
         S_LEN_HI: word_sel = len64[63:32];
         S_LEN_LO: word_sel = len64[31:0];
         default:  word_sel = '0;
      endcase

      out_valid_d    = out_valid_q;
      out_data_d     = out_data_q;
      out_first_d    = out_first_q;
      out_blk_last_d = out_blk_last_q;
      out_msg_last_d = out_msg_last_q;
      widx_d         = widx_q;
      if (gen) begin
         out_valid_d    = 1'b1;
         out_data_d     = word_sel;
         out_first_d    = (widx_q == '0);
         out_blk_last_d = (widx_q == LEN_LO_IDX);
         out_msg_last_d = (state_q == S_LEN_LO);
         widx_d         = widx_q + widx_t'(1);
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end

      cnt_d = cnt_q;
      if (accept) begin
         cnt_d = cnt_q + (in_last ? LEN_W'({nb, 3'b000}) : LEN_W'(32));
      end else if (gen && (state_q == S_LEN_LO)) begin
         cnt_d = '0;
      end

      // A new message may start in the same cycle the length word leaves.
      busy_d = busy_q;
      if (out_valid_q && out_ready && out_msg_last_q) busy_d = 1'b0;
      if (accept) busy_d = 1'b1;
   end

endmodule
